preg_free_list: RTL and testbench

- Scheduler for the physical-register pool used by the rename stage.
- Hands out up to two free P-reg tags per cycle to the renamer's two destination slots.
- Accepts up to two retired tags per cycle from the ROB and raises the rename stall.
- Circular FIFO of tags plus an in-list bitmap for double-free detection; P-reg 0 is never allocated or stored.

---
 rtl/rename_pkg.sv | 17 +
 rtl/ptr_wrap_add.sv | 21 ++
 rtl/preg_free_list.sv | 130 +++++++++++++
 tb/tb_preg_free_list.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage definitions used by the free list, renamer and ROB.
//   NUM_A_REGS : architectural register count (identity-mapped at reset)
//   NUM_P_REGS : physical register count
//   TAG_W      : physical tag width
//   p_tag_t    : physical register tag
//   cnt2()     : population count of two request/valid bits
package rename_pkg;
  localparam int NUM_A_REGS = 32;
  localparam int NUM_P_REGS = 64;
  localparam int TAG_W      = $clog2(NUM_P_REGS);

  typedef logic [TAG_W-1:0] p_tag_t;

  function automatic logic [1:0] cnt2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/ptr_wrap_add.sv
// Circular pointer increment: o_sum = (i_ptr + i_inc) mod DEPTH, i_inc in {0,1,2}.
// DEPTH need not be a power of two, so the wrap is an explicit compare/subtract.
//   i_ptr : current pointer, always < DEPTH
//   i_inc : increment 0..2
//   o_sum : wrapped result
module ptr_wrap_add #(
  parameter int DEPTH = 63,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [PW-1:0] i_ptr,
  input  logic [1:0]    i_inc,
  output logic [PW-1:0] o_sum
);
  logic [PW:0] w_sum;
  logic [PW:0] w_sub;

  assign w_sum = {1'b0, i_ptr} + {{(PW-1){1'b0}}, i_inc};
  assign w_sub = w_sum - (PW+1)'(DEPTH);
  // i_ptr < DEPTH and i_inc <= 2 keep w_sum below 2*DEPTH, so one subtract suffices.
  assign o_sum = (w_sum >= (PW+1)'(DEPTH)) ? w_sub[PW-1:0] : w_sum[PW-1:0];
endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list for a two-wide rename stage.
// Circular FIFO of free tags plus an in-list bitmap that rejects double frees.
// Tag 0 is never stored or handed out.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   alloc_req0_i/1_i      : rename slots requesting a tag
//   alloc_gnt_o           : every asserted request is granted (all-or-nothing)
//   alloc_tag0_o/1_o      : compacted tags for slot 0 / slot 1
//   free_en0_i/1_i        : ROB returns a tag (free0 is processed before free1)
//   free_tag0_i/1_i       : returned tags
//   free_count_o          : tags currently in the list
//   stall_o               : fewer than two tags available
//   err_o                 : sticky bad-free indication
module preg_free_list #(
  parameter int NUM_A_REGS = rename_pkg::NUM_A_REGS,
  parameter int NUM_P_REGS = rename_pkg::NUM_P_REGS,
  parameter int TAG_W      = $clog2(NUM_P_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_req0_i,
  input  logic             alloc_req1_i,
  output logic             alloc_gnt_o,
  output logic [TAG_W-1:0] alloc_tag0_o,
  output logic [TAG_W-1:0] alloc_tag1_o,
  input  logic             free_en0_i,
  input  logic             free_en1_i,
  input  logic [TAG_W-1:0] free_tag0_i,
  input  logic [TAG_W-1:0] free_tag1_i,
  output logic [TAG_W:0]   free_count_o,
  output logic             stall_o,
  output logic             err_o
);
  import rename_pkg::*;

  localparam int DEPTH   = NUM_P_REGS - 1;
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = TAG_W + 1;
  localparam int RST_CNT = NUM_P_REGS - NUM_A_REGS;

  logic [TAG_W-1:0]      r_fifo [DEPTH];
  logic [NUM_P_REGS-1:0] r_inlist;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_err;

  logic [1:0]    w_nreq;
  logic          w_gnt;
  logic [1:0]    w_pop;
  logic [PW-1:0] w_rd1_ptr;
  logic [PW-1:0] w_head_nxt;
  logic          w_acc0;
  logic          w_acc1;
  logic [1:0]    w_push;
  logic [PW-1:0] w_wr1_ptr;
  logic [PW-1:0] w_tail_nxt;
  logic          w_rej;
  logic [CW-1:0] w_count_nxt;

  // ---------------- allocation (evaluated on pre-free contents) ----------------
  assign w_nreq = cnt2(alloc_req0_i, alloc_req1_i);
  assign w_gnt  = (w_nreq == 2'd0) || (r_count >= CW'(w_nreq));
  assign w_pop  = w_gnt ? w_nreq : 2'd0;

  // Slot 1 reads head+1 only when slot 0 also consumes a tag (compaction).
  ptr_wrap_add #(.DEPTH(DEPTH), .PW(PW)) u_rd1 (
    .i_ptr(r_head), .i_inc({1'b0, alloc_req0_i}), .o_sum(w_rd1_ptr)
  );
  ptr_wrap_add #(.DEPTH(DEPTH), .PW(PW)) u_head_nxt (
    .i_ptr(r_head), .i_inc(w_pop), .o_sum(w_head_nxt)
  );

  assign alloc_gnt_o  = w_gnt;
  assign alloc_tag0_o = r_fifo[r_head];
  assign alloc_tag1_o = r_fifo[w_rd1_ptr];

  // ---------------- free ----------------
  // The bitmap is checked before this cycle's grant clears it, so freeing a tag
  // that is being allocated in the same cycle is caught as a double free.
  assign w_acc0 = free_en0_i && (free_tag0_i != '0) && !r_inlist[free_tag0_i];
  assign w_acc1 = free_en1_i && (free_tag1_i != '0) && !r_inlist[free_tag1_i] &&
                  !(free_en0_i && (free_tag1_i == free_tag0_i));
  assign w_push = cnt2(w_acc0, w_acc1);
  assign w_rej  = (free_en0_i && !w_acc0) || (free_en1_i && !w_acc1);

  // free1 lands right behind free0 when free0 was accepted, otherwise at tail.
  ptr_wrap_add #(.DEPTH(DEPTH), .PW(PW)) u_wr1 (
    .i_ptr(r_tail), .i_inc({1'b0, w_acc0}), .o_sum(w_wr1_ptr)
  );
  ptr_wrap_add #(.DEPTH(DEPTH), .PW(PW)) u_tail_nxt (
    .i_ptr(r_tail), .i_inc(w_push), .o_sum(w_tail_nxt)
  );

  assign w_count_nxt = r_count - CW'(w_pop) + CW'(w_push);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        r_fifo[i] <= (i < RST_CNT) ? TAG_W'(NUM_A_REGS + i) : '0;
      for (int i = 0; i < NUM_P_REGS; i++)
        r_inlist[i] <= (i >= NUM_A_REGS);
      r_head  <= '0;
      r_tail  <= PW'(RST_CNT % DEPTH);
      r_count <= CW'(RST_CNT);
      r_err   <= 1'b0;
    end else begin
      if (w_gnt) begin
        if (alloc_req0_i) r_inlist[alloc_tag0_o] <= 1'b0;
        if (alloc_req1_i) r_inlist[alloc_tag1_o] <= 1'b0;
      end
      // Accepted tags have a clear bit, so they never collide with a granted tag.
      if (w_acc0) begin
        r_fifo[r_tail]        <= free_tag0_i;
        r_inlist[free_tag0_i] <= 1'b1;
      end
      if (w_acc1) begin
        r_fifo[w_wr1_ptr]     <= free_tag1_i;
        r_inlist[free_tag1_i] <= 1'b1;
      end
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      if (w_rej) r_err <= 1'b1;
    end
  end

  assign free_count_o = r_count;
  assign stall_o      = (r_count < CW'(2));
  assign err_o        = r_err;
endmodule

// File: tb/tb_preg_free_list.sv
module tb_preg_free_list;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       alloc_req0_i, alloc_req1_i;
  logic       alloc_gnt_o;
  logic [5:0] alloc_tag0_o, alloc_tag1_o;
  logic       free_en0_i, free_en1_i;
  logic [5:0] free_tag0_i, free_tag1_i;
  logic [6:0] free_count_o;
  logic       stall_o;
  logic       err_o;

  always #5 clk_i = ~clk_i;

  preg_free_list dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_req0_i(alloc_req0_i), .alloc_req1_i(alloc_req1_i),
    .alloc_gnt_o(alloc_gnt_o), .alloc_tag0_o(alloc_tag0_o), .alloc_tag1_o(alloc_tag1_o),
    .free_en0_i(free_en0_i), .free_en1_i(free_en1_i),
    .free_tag0_i(free_tag0_i), .free_tag1_i(free_tag1_i),
    .free_count_o(free_count_o), .stall_o(stall_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: ordered queue of free tags plus a membership set.
  int mq[$];
  bit m_in[64];
  bit m_err;

  logic       last_gnt;
  logic [5:0] last_tag0, last_tag1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 64; i++) m_in[i] = 1'b0;
    for (int t = 32; t < 64; t++) begin
      mq.push_back(t);
      m_in[t] = 1'b1;
    end
    m_err = 1'b0;
  endtask

  // One clock: drive at negedge, check combinational outputs, commit at posedge,
  // check registered outputs at the following negedge.
  task automatic cyc(input bit rst, input bit r0, input bit r1,
                     input bit e0, input int t0, input bit e1, input int t1);
    int n;
    bit g, a0, a1;
    rst_i = rst; alloc_req0_i = r0; alloc_req1_i = r1;
    free_en0_i = e0; free_tag0_i = 6'(t0); free_en1_i = e1; free_tag1_i = 6'(t1);
    #1;
    n = int'(r0) + int'(r1);
    g = (n == 0) || (mq.size() >= n);
    last_gnt = alloc_gnt_o; last_tag0 = alloc_tag0_o; last_tag1 = alloc_tag1_o;
    if (!rst) begin
      chk("gnt", alloc_gnt_o, g);
      if (r0 && g) chk("tag0", alloc_tag0_o, mq[0]);
      if (r1 && g) chk("tag1", alloc_tag1_o, r0 ? mq[1] : mq[0]);
    end
    @(posedge clk_i);
    if (rst) model_reset();
    else begin
      a0 = e0 && (t0 != 0) && !m_in[t0];
      a1 = e1 && (t1 != 0) && !m_in[t1] && !(e0 && t1 == t0);
      if (g) repeat (n) begin
        m_in[mq[0]] = 1'b0;
        void'(mq.pop_front());
      end
      if (a0) begin mq.push_back(t0); m_in[t0] = 1'b1; end
      if (a1) begin mq.push_back(t1); m_in[t1] = 1'b1; end
      if ((e0 && !a0) || (e1 && !a1)) m_err = 1'b1;
    end
    @(negedge clk_i);
    chk("count", free_count_o, mq.size());
    chk("stall", stall_o, mq.size() < 2);
    chk("err", err_o, m_err);
  endtask

  function automatic int pick();
    int c[$];
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 63));
    for (int t = 1; t < 64; t++) if (!m_in[t]) c.push_back(t);
    if (c.size() == 0) return 0;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  typedef struct {
    bit rst, r0, r1, e0; int t0; bit e1; int t1;
    int gnt, tag0, tag1, cnt, err;   // -1 = not checked
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit r0, bit r1, bit e0, int t0, bit e1, int t1,
                              int gnt, int tag0, int tag1, int cnt, int err);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.e0 = e0; v.t0 = t0; v.e1 = e1; v.t1 = t1;
    v.gnt = gnt; v.tag0 = tag0; v.tag1 = tag1; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  initial begin
    rst_i = 1'b1; alloc_req0_i = 0; alloc_req1_i = 0;
    free_en0_i = 0; free_en1_i = 0; free_tag0_i = 0; free_tag1_i = 0;
    model_reset();
    @(negedge clk_i);

    // ---------------- directed vectors ----------------
    tbl.push_back(mk(1,0,0,0, 0,0, 0, -1,-1,-1,32,0));
    tbl.push_back(mk(0,1,1,0, 0,0, 0,  1,32,33,30,0));
    tbl.push_back(mk(0,0,1,0, 0,0, 0,  1,-1,34,29,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 0, -1,-1,-1,32,0));
    tbl.push_back(mk(0,0,0,1, 7,1, 7, -1,-1,-1,33,1));  // duplicate pair: one accepted
    tbl.push_back(mk(0,0,0,0, 0,0, 0, -1,-1,-1,33,1));  // sticky
    tbl.push_back(mk(1,0,0,0, 0,0, 0, -1,-1,-1,32,0));
    tbl.push_back(mk(0,1,0,0, 0,0, 0,  1,32,-1,31,0));
    tbl.push_back(mk(0,0,0,1,40,0, 0, -1,-1,-1,31,1));  // 40 still in list
    tbl.push_back(mk(1,0,0,0, 0,0, 0, -1,-1,-1,32,0));
    tbl.push_back(mk(0,0,0,1, 0,0, 0, -1,-1,-1,32,1));  // tag 0 dropped
    tbl.push_back(mk(1,0,0,0, 0,0, 0, -1,-1,-1,32,0));
    tbl.push_back(mk(0,1,0,1,32,0, 0,  1,32,-1,31,1));  // alloc+free same tag
    tbl.push_back(mk(0,1,1,0, 0,0, 0,  1,33,34,29,1));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].e0, tbl[i].t0, tbl[i].e1, tbl[i].t1);
      if (tbl[i].gnt  >= 0) chk($sformatf("v%0d_gnt", i),  last_gnt,  tbl[i].gnt);
      if (tbl[i].tag0 >= 0) chk($sformatf("v%0d_tag0", i), last_tag0, tbl[i].tag0);
      if (tbl[i].tag1 >= 0) chk($sformatf("v%0d_tag1", i), last_tag1, tbl[i].tag1);
      chk($sformatf("v%0d_cnt", i), free_count_o, tbl[i].cnt);
      chk($sformatf("v%0d_err", i), err_o, tbl[i].err);
    end

    // ---------------- drain to empty, free-then-allocate latency ----------------
    cyc(1,0,0,0,0,0,0);
    for (int i = 0; i < 16; i++) cyc(0,1,1,0,0,0,0);
    chk("drain_cnt", free_count_o, 0);
    chk("drain_stall", stall_o, 1);
    cyc(0,1,0,0,0,0,0);
    chk("empty_gnt", last_gnt, 0);
    chk("empty_cnt", free_count_o, 0);
    cyc(0,1,0,1,5,0,0);
    chk("free_same_cycle_gnt", last_gnt, 0);
    cyc(0,1,0,0,0,0,0);
    chk("free_next_gnt", last_gnt, 1);
    chk("free_next_tag", last_tag0, 5);

    // ---------------- wrap: two-wide push and pop straddling slot 62 ----------------
    cyc(1,0,0,0,0,0,0);
    for (int i = 0; i < 15; i++) cyc(0,1,1,0,0,0,0);
    for (int i = 0; i < 30; i++) cyc(0,0,0,1,32+i,0,0);
    cyc(0,1,1,0,0,0,0);
    chk("pre_wrap_tag0", last_tag0, 62);
    chk("pre_wrap_tag1", last_tag1, 63);
    cyc(0,0,0,1,63,1,62);
    chk("wrap_push_cnt", free_count_o, 32);
    for (int i = 0; i < 16; i++) cyc(0,1,1,0,0,0,0);
    chk("wrap_pop_tag0", last_tag0, 63);
    chk("wrap_pop_tag1", last_tag1, 62);

    // ---------------- mid-sequence reset ----------------
    cyc(0,0,0,1,0,0,0);
    cyc(1,1,1,1,9,1,10);
    chk("midrst_cnt", free_count_o, 32);
    chk("midrst_err", err_o, 0);
    cyc(0,1,0,0,0,0,0);
    chk("midrst_tag0", last_tag0, 32);

    // ---------------- randomized against the model ----------------
    cyc(1,0,0,0,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      bit rr, q0, q1, f0, f1;
      int x0, x1;
      rr = ($urandom_range(0, 299) == 0);
      q0 = $urandom_range(0, 1); q1 = $urandom_range(0, 1);
      f0 = $urandom_range(0, 1); f1 = $urandom_range(0, 1);
      x0 = pick();
      x1 = ($urandom_range(0, 15) == 0) ? x0 : pick();
      cyc(rr, q0, q1, f0, x0, f1, x1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
